// File: rtl/cjg_muldiv.sv
// Sequential multiply/divide unit: signed shift-add multiply or unsigned restoring
// divide, one result bit per clock, with ALU-format c/n/v/z flags.
module cjg_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             c,
  output logic             n,
  output logic             v,
  output logic             z,
  input  logic             scan_in0,
  input  logic             scan_en,
  input  logic             test_mode,
  output logic             scan_out0
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             n_q, n_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_s;
  logic               mul_ovf;
  logic [WIDTH-1:0]   fin_result;
  logic               dft_unused;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic s);
    return s ? (~p + 1'b1) : p;
  endfunction

  // Multiply: hi accumulates partial sums, lo holds the multiplier and collects
  // the low product bits as everything shifts right.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: {hi, lo} = {remainder, dividend/quotient} shifting left.
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ge   = (div_sh >= {1'b0, opnd_q});

  assign prod_s     = apply_sign({hi_q, lo_q}, sign_q);
  assign mul_ovf    = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
  assign fin_result = op_q ? lo_q : prod_s[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    done_d   = 1'b0;
    result_d = result_q;
    rem_d    = rem_q;
    n_d      = n_q;
    v_d      = v_q;
    z_d      = z_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = CNT_W'(WIDTH);
          op_d    = op;
          hi_d    = '0;
          if (op) begin
            sign_d = 1'b0;
            lo_d   = a;
            opnd_d = b;
          end else begin
            sign_d = a[WIDTH-1] ^ b[WIDTH-1];
            lo_d   = abs_val(b);
            opnd_d = abs_val(a);
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q) begin
          hi_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = fin_result;
        rem_d    = op_q ? hi_q : '0;
        n_d      = fin_result[WIDTH-1];
        z_d      = (fin_result == '0);
        v_d      = op_q ? (opnd_q == '0) : mul_ovf;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      n_q      <= n_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  // The done-pulse cycle still counts as busy so busy and done fall together.
  assign busy      = (state_q != S_IDLE) | done_q;
  assign done      = done_q;
  assign result    = result_q;
  assign rem       = rem_q;
  assign c         = 1'b0;
  assign n         = n_q;
  assign v         = v_q;
  assign z         = z_q;
  assign scan_out0 = 1'b0;

  assign dft_unused = scan_in0 ^ scan_en ^ test_mode;

endmodule

// File: tb/tb_cjg_muldiv.sv
// Randomized self-checking bench for cjg_muldiv against an arithmetic reference model.
module tb_cjg_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         scan_in0 = 1'b0;
  logic         scan_en = 1'b0;
  logic         test_mode = 1'b0;
  logic         busy, done, c, n, v, z, scan_out0;
  logic [W-1:0] result, rem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cjg_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .rem(rem),
    .c(c), .n(n), .v(v), .z(z),
    .scan_in0(scan_in0), .scan_en(scan_en), .test_mode(test_mode),
    .scan_out0(scan_out0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed 64-bit multiply, plain unsigned divide.
  task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] er, output logic [W-1:0] erm,
                       output logic en, output logic ev, output logic ez);
    longint p;
    if (!o) begin
      p   = longint'($signed(x)) * longint'($signed(y));
      er  = p[W-1:0];
      erm = '0;
      ev  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (y == '0) begin
      er  = '1;
      erm = x;
      ev  = 1'b1;
    end else begin
      er  = x / y;
      erm = x % y;
      ev  = 1'b0;
    end
    en = er[W-1];
    ez = (er == '0);
  endtask

  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int p1, input int p2);
    logic [W-1:0] er, erm;
    logic         en, ev, ez;
    int           lat, bcyc;
    model(o, x, y, er, erm, en, ev, ez);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
    bcyc = busy ? 1 : 0;
    lat  = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (busy) bcyc++;
      if (done) begin
        lat = i;
        break;
      end
      start = (i == p1) || (i == p2);
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(W + 1));
    chk("result", {32'b0, result}, {32'b0, er});
    chk("rem", {32'b0, rem}, {32'b0, erm});
    chk("flags_cnvz", {60'b0, c, n, v, z}, {60'b0, 1'b0, en, ev, ez});
    @(posedge clk); #1;
    if (busy) bcyc++;
    chk("done_single", {63'b0, done}, 64'd0);
    chk("busy_cycles", 64'(bcyc), 64'(W + 2));
    chk("result_hold", {32'b0, result}, {32'b0, er});
  endtask

  initial begin
    logic [W-1:0] er, erm, x, y;
    logic         en, ev, ez, o;
    int           t[$];
    int           dcount;

    #12;
    chk("reset_outs", {busy, done, c, n, v, z, scan_out0, result, rem},
        {7'b0, 32'b0, 32'b0});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", {63'b0, busy}, 64'd0);

    do_op(1'b0, 32'd7, 32'hFFFFFFFA, 0, 0);
    do_op(1'b0, 32'h00010000, 32'h00010000, 0, 0);
    do_op(1'b0, 32'h80000000, 32'd1, 0, 0);
    do_op(1'b0, 32'h80000000, 32'h80000000, 0, 0);
    do_op(1'b1, 32'hFFFFFFFF, 32'h10, 0, 0);
    do_op(1'b1, 32'h1234, 32'd0, 0, 0);
    do_op(1'b0, 32'd123456, 32'hFFFFF000, 5, 20);
    do_op(1'b1, 32'd100, 32'd7, 0, 0);

    // start held high: back-to-back operations
    model(1'b0, 32'd12345, 32'hFFFF0001, er, erm, en, ev, ez);
    @(negedge clk);
    op = 1'b0; a = 32'd12345; b = 32'hFFFF0001; start = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (done) begin
        t.push_back(i);
        chk("held_result", {32'b0, result}, {32'b0, er});
      end
    end
    start = 1'b0;
    chk("held_count", 64'(t.size()), 64'd4);
    for (int k = 1; k < t.size(); k++) chk("held_period", 64'(t[k] - t[k-1]), 64'(W + 2));
    repeat (40) @(posedge clk);

    // reset in the middle of a divide
    do_op(1'b1, 32'd100, 32'd7, 0, 0);
    @(negedge clk);
    op = 1'b1; a = 32'h0ABCDEF0; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_outs", {busy, done, c, n, v, z, scan_out0, result, rem},
        {7'b0, 32'b0, 32'b0});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    do_op(1'b1, 32'h0ABCDEF0, 32'd3, 0, 0);

    for (int k = 0; k < 14; k++) begin
      o = 1'($urandom);
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 2) == 0) y = $urandom_range(0, 20);
      if (!o && $urandom_range(0, 1) == 0) x = $urandom_range(0, 50000);
      if (!o && $urandom_range(0, 1) == 0) y = 32'($signed(-$urandom_range(0, 50000)));
      do_op(o, x, y, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
